// File: rtl/user_flash_writer.sv
// Write-side controller for the GW1NR-9 user flash: word program and row erase,
// sequencing xe/ye/prog/erase/nvstr with elaboration-time phase timing.
module user_flash_writer #(
   parameter longint unsigned CLK_FREQ   = 27_000_000,
   parameter longint unsigned T_NVS_NS   = 5_000,
   parameter longint unsigned T_PGS_NS   = 10_000,
   parameter longint unsigned T_PROG_NS  = 16_000,
   parameter longint unsigned T_NVH_NS   = 5_000,
   parameter longint unsigned T_ERASE_NS = 100_000_000,
   parameter longint unsigned T_NVH1_NS  = 100_000,
   parameter longint unsigned T_RCV_NS   = 10_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        select,
   input  logic [3:0]  wstrb,
   input  logic [15:0] addr,
   input  logic [31:0] data_i,
   output logic        ready,
   output logic        error,
   output logic        busy,
   output logic        xe,
   output logic        ye,
   output logic        se,
   output logic        prog,
   output logic        erase,
   output logic        nvstr,
   output logic [8:0]  xadr,
   output logic [5:0]  yadr,
   output logic [31:0] din,
   output logic        inv_valid,
   output logic [8:0]  inv_row
);

   function automatic logic [31:0] ns2cyc(input longint unsigned t_ns);
      longint unsigned c;
      c = (t_ns * CLK_FREQ + 64'd999_999_999) / 64'd1_000_000_000;
      return (c == 64'd0) ? 32'd1 : c[31:0];
   endfunction

   // Counter load values are phase length minus one: the change lands on the Nth edge.
   localparam logic [31:0] NVS_LD   = ns2cyc(T_NVS_NS)   - 32'd1;
   localparam logic [31:0] PGS_LD   = ns2cyc(T_PGS_NS)   - 32'd1;
   localparam logic [31:0] PROG_LD  = ns2cyc(T_PROG_NS)  - 32'd1;
   localparam logic [31:0] NVH_LD   = ns2cyc(T_NVH_NS)   - 32'd1;
   localparam logic [31:0] ERASE_LD = ns2cyc(T_ERASE_NS) - 32'd1;
   localparam logic [31:0] NVH1_LD  = ns2cyc(T_NVH1_NS)  - 32'd1;
   localparam logic [31:0] RCV_LD   = ns2cyc(T_RCV_NS)   - 32'd1;

   typedef enum logic [3:0] {IDLE, NVS, PGS, PROG, PGH, NVH, RCV, ERASE, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic        op_q, op_d;
   logic        ready_q, ready_d, error_q, error_d, busy_q, busy_d;
   logic        xe_q, xe_d, ye_q, ye_d, prog_q, prog_d, erase_q, erase_d, nvstr_q, nvstr_d;
   logic [8:0]  xadr_q, xadr_d;
   logic [5:0]  yadr_q, yadr_d;
   logic [31:0] din_q, din_d;
   logic        inv_valid_q, inv_valid_d;
   logic [8:0]  inv_row_q, inv_row_d;
   logic        last;

   always_comb begin
      state_d     = state_q;
      cnt_d       = (cnt_q != 32'd0) ? cnt_q - 32'd1 : cnt_q;
      op_d        = op_q;
      ready_d     = 1'b0;
      error_d     = error_q;
      busy_d      = busy_q;
      xe_d        = xe_q;
      ye_d        = ye_q;
      prog_d      = prog_q;
      erase_d     = erase_q;
      nvstr_d     = nvstr_q;
      xadr_d      = xadr_q;
      yadr_d      = yadr_q;
      din_d       = din_q;
      inv_valid_d = 1'b0;
      inv_row_d   = inv_row_q;
      last        = (cnt_q == 32'd0);
      case (state_q)
         IDLE: if (select) begin
            if (wstrb != 4'hF || addr[14:6] > 9'd303) begin
               ready_d = 1'b1;
               error_d = 1'b1;
               state_d = DONE;
            end else begin
               op_d    = addr[15];
               xadr_d  = addr[14:6];
               yadr_d  = addr[5:0];
               din_d   = data_i;
               busy_d  = 1'b1;
               xe_d    = 1'b1;
               prog_d  = ~addr[15];
               erase_d = addr[15];
               cnt_d   = NVS_LD;
               state_d = NVS;
            end
         end
         NVS: if (last) begin
            nvstr_d = 1'b1;
            state_d = op_q ? ERASE : PGS;
            cnt_d   = op_q ? ERASE_LD : PGS_LD;
         end
         PGS: if (last) begin
            ye_d    = 1'b1;
            cnt_d   = PROG_LD;
            state_d = PROG;
         end
         PROG: if (last) begin
            ye_d    = 1'b0;
            state_d = PGH;
         end
         PGH: begin
            prog_d  = 1'b0;
            cnt_d   = NVH_LD;
            state_d = NVH;
         end
         ERASE: if (last) begin
            erase_d = 1'b0;
            cnt_d   = NVH1_LD;
            state_d = NVH;
         end
         NVH: if (last) begin
            nvstr_d = 1'b0;
            cnt_d   = RCV_LD;
            state_d = RCV;
         end
         RCV: if (last) begin
            xe_d        = 1'b0;
            ready_d     = 1'b1;
            error_d     = 1'b0;
            inv_valid_d = 1'b1;
            inv_row_d   = xadr_q;
            state_d     = DONE;
         end
         DONE: begin
            busy_d  = 1'b0;
            error_d = 1'b0;
            cnt_d   = 32'd0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= 32'd0;
         op_q        <= 1'b0;
         ready_q     <= 1'b0;
         error_q     <= 1'b0;
         busy_q      <= 1'b0;
         xe_q        <= 1'b0;
         ye_q        <= 1'b0;
         prog_q      <= 1'b0;
         erase_q     <= 1'b0;
         nvstr_q     <= 1'b0;
         xadr_q      <= 9'd0;
         yadr_q      <= 6'd0;
         din_q       <= 32'd0;
         inv_valid_q <= 1'b0;
         inv_row_q   <= 9'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         ready_q     <= ready_d;
         error_q     <= error_d;
         busy_q      <= busy_d;
         xe_q        <= xe_d;
         ye_q        <= ye_d;
         prog_q      <= prog_d;
         erase_q     <= erase_d;
         nvstr_q     <= nvstr_d;
         xadr_q      <= xadr_d;
         yadr_q      <= yadr_d;
         din_q       <= din_d;
         inv_valid_q <= inv_valid_d;
         inv_row_q   <= inv_row_d;
      end
   end

   assign ready     = ready_q;
   assign error     = error_q;
   assign busy      = busy_q;
   assign xe        = xe_q;
   assign ye        = ye_q;
   assign se        = 1'b0;
   assign prog      = prog_q;
   assign erase     = erase_q;
   assign nvstr     = nvstr_q;
   assign xadr      = xadr_q;
   assign yadr      = yadr_q;
   assign din       = din_q;
   assign inv_valid = inv_valid_q;
   assign inv_row   = inv_row_q;

endmodule

// File: doc/user_flash_writer.md
Name: user_flash_writer

Overview:
- Write-side controller for the GW1NR-9 user flash (304 rows x 64 cols x 32b). Performs word program and row (page) erase on behalf of the picoRV bus.
- Shares the flash primitive with the cached read controller through an external mux; `busy` is the mux select.
- Pulses `inv_valid`/`inv_row` so the read cache can drop stale lines for the affected row.

Parameters:
- CLK_FREQ, 27_000_000, clock frequency in Hz.
- T_NVS_NS, 5_000, prog/erase to nvstr setup time.
- T_PGS_NS, 10_000, nvstr to ye setup time (program only).
- T_PROG_NS, 16_000, ye high time per word.
- T_NVH_NS, 5_000, prog low to nvstr low hold time (program).
- T_ERASE_NS, 100_000_000, erase pulse width.
- T_NVH1_NS, 100_000, erase low to nvstr low hold time (erase).
- T_RCV_NS, 10_000, nvstr low to xe low recovery time.
- Each time converts to cycles as ceil(T*CLK_FREQ/1e9), with a minimum of 1. Conversion is evaluated at elaboration.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- select  in  1  bus request, held by the master until `ready`
- wstrb  in  4  byte strobes
- addr  in  16  [15]=op (0 program word, 1 erase row); [14:6] row; [5:0] column
- data_i  in  32  word to program
- ready  out  1  one-cycle completion pulse
- error  out  1  valid with `ready`; 1 = request rejected
- busy  out  1  high from request acceptance through DONE
- xe, ye, se, prog, erase, nvstr  out  1 each  flash control signals
- xadr  out  9  flash row address
- yadr  out  6  flash column address
- din  out  32  flash program data
- inv_valid  out  1  one-cycle pulse, cache invalidate
- inv_row  out  9  row to invalidate

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0. Asserting reset mid-operation drops every flash control low immediately (asynchronously). The interrupted word/row content is undefined, and there is no resume.
- `se` is tied 0 (read path only). `xadr`, `yadr` and `din` are registered at acceptance and held until IDLE.
- A single down-counter (32b) times each phase. A phase of N cycles means the signal change occurs N cycles after the previous change.
- IDLE, when `select` = 1:
  - wstrb == 0 (read): go to DONE with error = 1. No flash activity.
  - wstrb != 4'hF and != 0 (partial write): DONE, error = 1.
  - wstrb == 4'hF, addr[15]=0: latch, busy = 1, xe = 1, prog = 1, go to NVS.
  - wstrb == 4'hF, addr[15]=1: latch, xe = 1, erase = 1, go to NVS.
  - Row > 303: DONE, error = 1.
- Program sequence:
  - NVS (T_NVS): nvstr = 1, then PGS.
  - PGS (T_PGS): ye = 1, then PROG.
  - PROG (T_PROG): ye = 0, then PGH.
  - PGH (1 cycle): prog = 0, then NVH.
  - NVH (T_NVH): nvstr = 0, then RCV.
  - RCV (T_RCV): xe = 0, then DONE.
- Erase sequence:
  - NVS: nvstr = 1, then ERASE.
  - ERASE (T_ERASE): erase = 0, then NVH (using T_NVH1).
  - NVH: nvstr = 0, then RCV.
  - RCV: xe = 0, then DONE.
- DONE: ready = 1 for one cycle and busy drops. For a successful program or erase, inv_valid = 1 in the same cycle with inv_row = latched row. Next state is IDLE.
- `select` still high in the cycle after DONE is treated as a new request; the master must drop it on `ready`.
- `select`, `addr` and `data_i` changes while busy are ignored.
- Program-after-erase ordering is the software's responsibility. No verify step; no read-modify-write.
- Signals prog and erase are never high simultaneously, and ye is never high outside PROG.

Test Plan:
- CLK_FREQ=1_000_000, select, wstrb=F, addr=16'h0085, data_i=32'hDEADBEEF -> xadr=2, yadr=5, din=DEADBEEF. nvstr rises 5 cycles after prog, ye high for exactly 16 cycles, xe falls 10 cycles after nvstr. ready+inv_valid with inv_row=2, error=0.
- CLK_FREQ=1_000_000, T_ERASE_NS=50_000, addr=16'h8140 -> row 5 erased. erase high 5+50 cycles, nvstr falls 100 cycles after erase, prog/ye never high. inv_row=5.
- wstrb=4'b0011 or wstrb=0 -> ready one cycle after select with error=1. All flash controls stay 0 and inv_valid stays 0.
- Erase with addr[14:6]=304 -> error=1, no flash activity.
- Reset_n pulled low during PROG -> within the same cycle xe/ye/prog/nvstr=0 and busy=0. After release, a new program completes normally.
- Toggle addr/data_i during a program -> xadr/yadr/din unchanged, and exactly one ready pulse.
